serial_code_decoder: RTL and testbench
======================================

# serial_code_decoder

Receive-side companion to the parallel code converters. Accepts a serial stream of 4-bit Gray-coded or Excess-3-coded nibbles, MSB first, and reassembles each nibble. It decodes every nibble to plain 4-bit binary and delivers it over a valid/ready handshake. A frame of NIBBLES nibbles is opened by `start` and closed by a one-cycle `stop` pulse, matching the start/stop framing used by the converter controller.

## Interface
- NIBBLES, default 4: nibbles per frame, range 1..16.
- XS3_CHECK, default 1: 1 enables the Excess-3 invalid-code flag; 0 forces `code_err` to 0.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame request; honoured only in IDLE.
- mode  in  1  0 = Gray, 1 = Excess-3; latched on the edge that accepts `start`.
- sin  in  1  serial code bit, MSB of each nibble first.
- sin_valid  in  1  `sin` qualifier.
- sin_ready  out  1  block can consume a bit; a bit is taken on an edge where sin_valid and sin_ready are both 1.
- dout  out  4  decoded binary nibble.
- code_err  out  1  qualifies `dout`: Excess-3 code outside 0011..1100.
- dout_valid  out  1  `dout`/`code_err` valid.
- dout_ready  in  1  consumer accepts; transfer on an edge where dout_valid and dout_ready are both 1.
- busy  out  1  frame in progress (state != IDLE).
- stop  out  1  one-cycle pulse: frame complete.

## Operation
- The block uses a 4-bit shift register `sreg`, a 2-bit bit counter, a nibble counter of width clog2(NIBBLES)+1, and a latched `mode_q`.
- **States:**
  - IDLE: on `start`=1, latch `mode`, clear the counters, and go to SHIFT.
  - SHIFT: `sin_ready`=1. On each accepted bit, `sreg` <= {sreg[2:0], sin} and bit_cnt++.
    - When the 4th bit is accepted (bit_cnt==3), the decode of {sreg[2:0], sin} is registered into `dout`/`code_err`, `dout_valid` is set, bit_cnt wraps to 0, and the state moves to OUT.
  - OUT: `sin_ready`=0. `dout`, `code_err` and `dout_valid` are held stable until the transfer.
    - On transfer: if nib_cnt==NIBBLES-1, go to DONE; otherwise nib_cnt++ and go to SHIFT.
  - DONE: `stop`=1 for exactly this cycle, then IDLE.
- **Gray decode** (code c): b3=c3, b2=b3^c2, b1=b2^c1, b0=b1^c0.
- **Excess-3 decode:** b = (c - 4'd3) mod 16, 4-bit wraparound.
  - `code_err` = 1 when c < 3 or c > 12, provided XS3_CHECK=1.
  - The wrapped value is still presented on `dout`.
- In Gray mode `code_err` is always 0.
- **Boundary rules:**
  - `start` in any state other than IDLE is ignored; `mode` changes mid-frame are ignored.
  - `sin_valid` while `sin_ready`=0: the bit is not consumed and not stored.
  - `dout_ready` while `dout_valid`=0 has no effect.
  - `sin_valid` gaps in SHIFT stall the frame indefinitely; there is no timeout.
  - `rst_n`=0 in any state: on that edge the block goes to IDLE and all outputs take their reset values. A partial nibble or an undelivered `dout` is discarded; no `stop` is produced.
- **Reset values:** `sin_ready`=0, `dout`=0000, `code_err`=0, `dout_valid`=0, `busy`=0, `stop`=0; internal `sreg`, counters and `mode_q` = 0.

## Timing
- Start: `start` accepted at edge E0; SHIFT and `sin_ready`=1 from the cycle after E0.
- Decode latency: 4th bit accepted at edge E1; `dout_valid`=1 in the cycle immediately after E1.
- Throughput: a transfer at edge E2 (not the last nibble) gives `sin_ready`=1 in the cycle after E2. Best case is 5 cycles per nibble (4 bits + 1 OUT cycle).
- Frame end: the last transfer at edge E3 gives `stop`=1 in cycle E3+1 and `busy`=0 from E3+2.
  - Earliest next `start` is accepted at the edge ending cycle E3+2.
- `sin_ready`, `dout_valid` and `stop` are registered or decoded from state only, with no combinational path from inputs.
- **Minimum frame length**, NIBBLES=4, no stalls: `start` to `stop` = 1 + 4×5 + 1 cycles.

## Test plan
- **Gray, NIBBLES=4, continuous valid:** codes 0000, 0110, 1101, 1000 -> `dout` 0000, 0100, 1001, 1111, all with `code_err`=0; one `stop` pulse one cycle after the 4th transfer.
- **Excess-3:** codes 0011, 1000, 1100, 0001 -> `dout` 0000, 0101, 1001, 1110; `code_err` 0, 0, 0, 1. With XS3_CHECK=0, the same stimulus gives `code_err` all 0.
- **Backpressure:** hold `dout_ready`=0 for 6 cycles with `sin_valid`=1 toggling `sin`.
  - Required: `dout`/`code_err` stable, `sin_ready`=0, no bits consumed.
  - After release, the next nibble is decoded from fresh bits only.
- **Input gaps:** `sin_valid` low for 3 cycles between every bit -> the decoded values are identical to the continuous run, and `dout_valid` rises exactly 1 cycle after each 4th accepted bit.
- **Reset mid-frame:** assert `rst_n`=0 after 2 bits of nibble 2.
  - Required: all outputs at reset values on the next cycle.
  - A new frame with Gray code 0110 yields 0100.
- **Start/mode while busy:** pulse `start` and flip `mode` during SHIFT and OUT -> no restart, decode keeps the latched mode, exactly one `stop` pulse per frame.

Source files
------------

// File: rtl/serial_code_decoder_if.sv
// Bundles the serial input stream, the decoded output stream and the framing
// signals of serial_code_decoder.
interface serial_code_decoder_if;
  logic       start;
  logic       mode;
  logic       sin;
  logic       sin_valid;
  logic       sin_ready;
  logic [3:0] dout;
  logic       code_err;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       stop;

  // Decoder side
  modport slave (
    input  start, mode, sin, sin_valid, dout_ready,
    output sin_ready, dout, code_err, dout_valid, busy, stop
  );

  // Stimulus / consumer side
  modport master (
    output start, mode, sin, sin_valid, dout_ready,
    input  sin_ready, dout, code_err, dout_valid, busy, stop
  );
endinterface

// File: rtl/serial_code_decoder.sv
// Reassembles MSB-first serial Gray or Excess-3 nibbles, decodes each to binary
// and hands it out over valid/ready; frames of NIBBLES nibbles end with a stop pulse.
module serial_code_decoder #(
  parameter int unsigned NIBBLES   = 4,
  parameter bit          XS3_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_code_decoder_if.slave bus
);

  localparam int unsigned NCW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       sreg, sreg_n;
  logic [1:0]       bit_cnt, bit_cnt_n;
  logic [NCW-1:0]   nib_cnt, nib_cnt_n;
  logic             mode_q, mode_n;
  logic [3:0]       dout_n;
  logic             err_n;
  logic             dv_n;

  // Decode a completed code nibble; returns {code_err, binary}
  function automatic logic [4:0] decode(input logic [3:0] c, input logic xs3);
    logic [3:0] b;
    logic       e;
    if (xs3) begin
      b = c - 4'd3;
      e = XS3_CHECK && ((c < 4'd3) || (c > 4'd12));
    end else begin
      b[3] = c[3];
      b[2] = b[3] ^ c[2];
      b[1] = b[2] ^ c[1];
      b[0] = b[1] ^ c[0];
      e    = 1'b0;
    end
    return {e, b};
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    nib_cnt_n = nib_cnt;
    mode_n    = mode_q;
    dout_n    = bus.dout;
    err_n     = bus.code_err;
    dv_n      = bus.dout_valid;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mode_n    = bus.mode;
          bit_cnt_n = 2'd0;
          nib_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid && bus.sin_ready) begin
          sreg_n    = {sreg[2:0], bus.sin};
          bit_cnt_n = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            {err_n, dout_n} = decode({sreg[2:0], bus.sin}, mode_q);
            dv_n            = 1'b1;
            state_n         = OUT;
          end
        end
      end
      OUT: begin
        if (bus.dout_ready) begin
          dv_n = 1'b0;
          if (nib_cnt == NCW'(NIBBLES - 1)) begin
            state_n = DONE;
          end else begin
            nib_cnt_n = nib_cnt + NCW'(1);
            state_n   = SHIFT;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; status flags are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sreg           <= 4'd0;
      bit_cnt        <= 2'd0;
      nib_cnt        <= '0;
      mode_q         <= 1'b0;
      bus.dout       <= 4'd0;
      bus.code_err   <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.sin_ready  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.stop       <= 1'b0;
    end else begin
      state          <= state_n;
      sreg           <= sreg_n;
      bit_cnt        <= bit_cnt_n;
      nib_cnt        <= nib_cnt_n;
      mode_q         <= mode_n;
      bus.dout       <= dout_n;
      bus.code_err   <= err_n;
      bus.dout_valid <= dv_n;
      bus.sin_ready  <= (state_n == SHIFT);
      bus.busy       <= (state_n != IDLE);
      bus.stop       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_serial_code_decoder.sv
// Directed bench for serial_code_decoder: Gray/Excess-3 frames, backpressure,
// input gaps, mid-frame reset and start/mode noise while busy.
module tb_serial_code_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   stop_cnt = 0;
  bit   noise = 1'b0;
  logic fmode = 1'b0;

  serial_code_decoder_if bus ();
  serial_code_decoder_if bus_nc ();

  serial_code_decoder #(.NIBBLES(4), .XS3_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  serial_code_decoder #(.NIBBLES(4), .XS3_CHECK(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .bus(bus_nc.slave)
  );

  assign bus_nc.start      = bus.start;
  assign bus_nc.mode       = bus.mode;
  assign bus_nc.sin        = bus.sin;
  assign bus_nc.sin_valid  = bus.sin_valid;
  assign bus_nc.dout_ready = bus.dout_ready;

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.stop === 1'b1) stop_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic meddle();
    if (noise) begin
      bus.start = 1'b1;
      bus.mode  = ~fmode;
    end
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    bus.sin       = b;
    bus.sin_valid = 1'b1;
    meddle();
    while (bus.sin_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("sin_ready_wait", 32'(bus.sin_ready), 1);
    tick();
  endtask

  task automatic send_nibble(input logic [3:0] code, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) chk("dv_before_4th", 32'(bus.dout_valid), 0);
      send_bit(code[i]);
      if (gap && i > 0) begin
        bus.sin_valid = 1'b0;
        repeat (3) tick();
      end
    end
    chk("dv_after_4th", 32'(bus.dout_valid), 1);
  endtask

  task automatic recv(input logic [3:0] ed, input logic ee, input logic ene, input bit keep);
    int n = 0;
    while (bus.dout_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("dout_valid_wait", 32'(bus.dout_valid), 1);
    chk("dout", 32'(bus.dout), 32'(ed));
    chk("code_err", 32'(bus.code_err), 32'(ee));
    chk("dout_nochk", 32'(bus_nc.dout), 32'(ed));
    chk("code_err_nochk", 32'(bus_nc.code_err), 32'(ene));
    bus.dout_ready = 1'b1;
    meddle();
    tick();
    if (!keep) bus.dout_ready = 1'b0;
  endtask

  task automatic start_frame(input logic m);
    fmode     = m;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("sin_ready_after_start", 32'(bus.sin_ready), 1);
  endtask

  task automatic nib(input logic [3:0] code, input logic [3:0] ed, input logic ee,
                     input logic ene, input bit gap, input bit last);
    int sc;
    send_nibble(code, gap);
    recv(ed, ee, ene, gap);
    if (!last) begin
      chk("sin_ready_next_nibble", 32'(bus.sin_ready), 1);
      chk("no_early_stop", 32'(bus.stop), 0);
    end else begin
      bus.start      = 1'b0;
      bus.mode       = fmode;
      bus.dout_ready = 1'b0;
      bus.sin_valid  = 1'b0;
      sc = stop_cnt;
      chk("stop_pulse", 32'(bus.stop), 1);
      chk("sin_ready_in_done", 32'(bus.sin_ready), 0);
      chk("busy_in_done", 32'(bus.busy), 1);
      tick();
      chk("stop_cleared", 32'(bus.stop), 0);
      chk("busy_cleared", 32'(bus.busy), 0);
      chk("one_stop_per_frame", 32'(stop_cnt), 32'(sc + 1));
    end
  endtask

  task automatic run_frame(input logic m, input logic [15:0] codes, input logic [15:0] ed,
                           input logic [3:0] ee, input logic [3:0] ene, input bit gap);
    start_frame(m);
    for (int k = 0; k < 4; k++)
      nib(codes[15-4*k -: 4], ed[15-4*k -: 4], ee[3-k], ene[3-k], gap, k == 3);
  endtask

  initial begin
    int sc;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.sin        = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_sin_ready", 32'(bus.sin_ready), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_code_err", 32'(bus.code_err), 0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_stop", 32'(bus.stop), 0);
    tick();

    // Gray, continuous valid
    run_frame(1'b0, 16'b0000_0110_1101_1000, 16'b0000_0100_1001_1111, 4'b0000, 4'b0000, 1'b0);
    tick();

    // Excess-3, continuous valid
    run_frame(1'b1, 16'b0011_1000_1100_0001, 16'b0000_0101_1001_1110, 4'b0001, 4'b0000, 1'b0);
    tick();

    // Input gaps of 3 cycles, dout_ready held high throughout
    run_frame(1'b0, 16'b0000_0110_1101_1000, 16'b0000_0100_1001_1111, 4'b0000, 4'b0000, 1'b1);
    tick();

    // Backpressure: dout held while sin toggles with valid high
    start_frame(1'b0);
    send_nibble(4'b1000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.sin       = ~bus.sin;
      bus.sin_valid = 1'b1;
      tick();
      chk("bp_dout", 32'(bus.dout), 32'hF);
      chk("bp_code_err", 32'(bus.code_err), 0);
      chk("bp_sin_ready", 32'(bus.sin_ready), 0);
      chk("bp_dout_valid", 32'(bus.dout_valid), 1);
    end
    recv(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("bp_sin_ready_release", 32'(bus.sin_ready), 1);
    nib(4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    nib(4'b1101, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    nib(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset after 2 bits of the second nibble
    start_frame(1'b0);
    nib(4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sc = stop_cnt;
    rst_n = 1'b0;
    bus.sin_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_sin_ready", 32'(bus.sin_ready), 0);
    chk("mrst_dout", 32'(bus.dout), 0);
    chk("mrst_code_err", 32'(bus.code_err), 0);
    chk("mrst_dout_valid", 32'(bus.dout_valid), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_stop", 32'(bus.stop), 0);
    repeat (2) tick();
    chk("mrst_no_stop", 32'(stop_cnt), 32'(sc));
    run_frame(1'b0, 16'b0110_1101_0000_1000, 16'b0100_1001_0000_1111, 4'b0000, 4'b0000, 1'b0);
    tick();

    // start pulses and mode flips during SHIFT and OUT of an Excess-3 frame
    noise = 1'b1;
    run_frame(1'b1, 16'b1111_0011_0101_1101, 16'b1100_0000_0010_1010, 4'b1001, 4'b0000, 1'b0);
    noise = 1'b0;
    bus.start = 1'b0;
    repeat (3) tick();
    chk("idle_after_noise", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
